// File: rtl/cmos_capture.sv
// rtl/cmos_capture.sv - CMOS byte stream to RGB565 pixel stream with start-up frame skip
// Pairs sensor bytes into pixels, frames them with sop/eop and flags frames cut short.
module cmos_capture #(
   parameter int H_AP        = 1280,
   parameter int V_AP        = 720,
   parameter int SKIP_FRAMES = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmos_vsync,
   input  logic        cmos_href,
   input  logic [7:0]  cmos_din,
   output logic        dout_sop,
   output logic        dout_eop,
   output logic        dout_vld,
   output logic [15:0] dout,
   output logic        frame_err
);

   localparam int HW = $clog2(H_AP + 1);
   localparam int VW = $clog2(V_AP + 1);
   localparam int FW = $clog2(SKIP_FRAMES + 2);

   localparam logic [HW-1:0] H_MAX  = HW'(H_AP);
   localparam logic [HW-1:0] H_LAST = HW'(H_AP - 1);
   localparam logic [VW-1:0] V_MAX  = VW'(V_AP);
   localparam logic [VW-1:0] V_LAST = VW'(V_AP - 1);
   localparam logic [FW-1:0] F_SKIP = FW'(SKIP_FRAMES);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SKIP    = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;

   logic          vsync_r1_q, vsync_r1_d;
   logic          href_r1_q, href_r1_d;
   logic [7:0]    din_r1_q, din_r1_d;
   logic          vsync_r2_q, vsync_r2_d;
   logic          href_r2_q, href_r2_d;
   logic [1:0]    state_q, state_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          phase_q, phase_d;
   logic [7:0]    hi_byte_q, hi_byte_d;
   logic          in_frame_q, in_frame_d;
   logic          vld_q, vld_d;
   logic          sop_q, sop_d;
   logic          eop_q, eop_d;
   logic [15:0]   dout_q, dout_d;
   logic          err_q, err_d;

   logic vs_rise;
   logic href_fall;
   logic capturing;

   assign vs_rise   = vsync_r1_q & ~vsync_r2_q;
   assign href_fall = ~href_r1_q & href_r2_q;
   assign capturing = (state_q == ST_CAPTURE);

   always_comb begin
      vsync_r1_d = cmos_vsync;
      href_r1_d  = cmos_href;
      din_r1_d   = cmos_din;
      vsync_r2_d = vsync_r1_q;
      href_r2_d  = href_r1_q;
      state_d    = state_q;
      fcnt_d     = fcnt_q;
      h_cnt_d    = h_cnt_q;
      v_cnt_d    = v_cnt_q;
      phase_d    = phase_q;
      hi_byte_d  = hi_byte_q;
      in_frame_d = in_frame_q;
      vld_d      = 1'b0;
      sop_d      = 1'b0;
      eop_d      = 1'b0;
      dout_d     = dout_q;
      err_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (vs_rise) begin
               if (SKIP_FRAMES == 0) begin
                  state_d = ST_CAPTURE;
               end else begin
                  state_d = ST_SKIP;
                  fcnt_d  = FW'(1);
               end
            end
         end
         ST_SKIP: begin
            if (vs_rise) begin
               if (fcnt_q == F_SKIP) begin
                  state_d = ST_CAPTURE;
               end else begin
                  fcnt_d = fcnt_q + FW'(1);
               end
            end
         end
         ST_CAPTURE: begin
            state_d = ST_CAPTURE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A vsync rise overrides any line event in the same cycle; a coincident byte opens the new frame.
      if (vs_rise) begin
         h_cnt_d    = '0;
         v_cnt_d    = '0;
         phase_d    = 1'b0;
         in_frame_d = 1'b0;
         if (capturing && in_frame_q) begin
            err_d = 1'b1;
         end
         if (capturing && href_r1_q) begin
            hi_byte_d = din_r1_q;
            phase_d   = 1'b1;
         end
      end else if (capturing) begin
         if (href_r1_q) begin
            if (!phase_q) begin
               hi_byte_d = din_r1_q;
               phase_d   = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (h_cnt_q < H_MAX) begin
                  h_cnt_d = h_cnt_q + HW'(1);
                  if (v_cnt_q < V_MAX) begin
                     vld_d  = 1'b1;
                     dout_d = {hi_byte_q, din_r1_q};
                     sop_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
                     eop_d  = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
                     if (sop_d) begin
                        in_frame_d = 1'b1;
                     end
                     if (eop_d) begin
                        in_frame_d = 1'b0;
                     end
                  end
               end
            end
         end else if (href_fall) begin
            h_cnt_d = '0;
            phase_d = 1'b0;
            if (v_cnt_q < V_MAX) begin
               v_cnt_d = v_cnt_q + VW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_r1_q <= 1'b0;
         href_r1_q  <= 1'b0;
         din_r1_q   <= 8'd0;
         vsync_r2_q <= 1'b0;
         href_r2_q  <= 1'b0;
         state_q    <= ST_IDLE;
         fcnt_q     <= '0;
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         phase_q    <= 1'b0;
         hi_byte_q  <= 8'd0;
         in_frame_q <= 1'b0;
         vld_q      <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         dout_q     <= 16'd0;
         err_q      <= 1'b0;
      end else begin
         vsync_r1_q <= vsync_r1_d;
         href_r1_q  <= href_r1_d;
         din_r1_q   <= din_r1_d;
         vsync_r2_q <= vsync_r2_d;
         href_r2_q  <= href_r2_d;
         state_q    <= state_d;
         fcnt_q     <= fcnt_d;
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         phase_q    <= phase_d;
         hi_byte_q  <= hi_byte_d;
         in_frame_q <= in_frame_d;
         vld_q      <= vld_d;
         sop_q      <= sop_d;
         eop_q      <= eop_d;
         dout_q     <= dout_d;
         err_q      <= err_d;
      end
   end

   assign dout_vld  = vld_q;
   assign dout_sop  = sop_q;
   assign dout_eop  = eop_q;
   assign dout      = dout_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_cmos_capture.sv
// tb/tb_cmos_capture.sv - self-checking bench for cmos_capture (8x4 frames, 2 skipped)
module tb_cmos_capture;

   localparam int H    = 8;
   localparam int V    = 4;
   localparam int SKIP = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmos_vsync = 1'b0;
   logic        cmos_href = 1'b0;
   logic [7:0]  cmos_din = 8'd0;
   logic        dout_sop, dout_eop, dout_vld, frame_err;
   logic [15:0] dout;

   cmos_capture #(.H_AP(H), .V_AP(V), .SKIP_FRAMES(SKIP)) dut (
      .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
      .cmos_din(cmos_din), .dout_sop(dout_sop), .dout_eop(dout_eop),
      .dout_vld(dout_vld), .dout(dout), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]      nlines;
      logic [5:0][7:0] len;
      logic [7:0]      exp_pix;
      logic            exp_sop;
      logic            exp_eop;
   } row_t;

   typedef struct packed {
      logic [15:0] d;
      logic        s;
      logic        e;
   } px_t;

   row_t tbl[11];
   px_t  expq[$];
   px_t  mon_p;

   int checks = 0;
   int errors = 0;

   // reference model state: frames are numbered by vsync rises since reset
   int vs_count, cur_line, exp_err, mdl_pix, byte_ctr;
   bit cur_cap, cur_sop, cur_eop;
   logic [7:0] lb[32];
   int ln;

   int pix_seen, sop_seen, eop_seen, err_seen;
   bit err_prev;
   logic [15:0] first_dout, last_dout;
   logic first_sop, last_eop;
   logic s_vld, s_sop, s_eop;
   logic [15:0] s_dout;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic sample();
      s_vld = dout_vld; s_sop = dout_sop; s_eop = dout_eop; s_dout = dout;
      if (dout_vld) begin
         if (pix_seen == 0) begin
            first_dout = dout;
            first_sop  = dout_sop;
         end
         last_dout = dout;
         last_eop  = dout_eop;
         pix_seen++;
         sop_seen += int'(dout_sop);
         eop_seen += int'(dout_eop);
         chk("pixel_expected", 32'(expq.size() != 0), 32'd1);
         if (expq.size() != 0) begin
            mon_p = expq.pop_front();
            chk("pixel", 32'({dout, dout_sop, dout_eop}), 32'({mon_p.d, mon_p.s, mon_p.e}));
         end
      end else begin
         chk("flags_idle", 32'({dout_sop, dout_eop}), 32'd0);
      end
      if (frame_err) begin
         err_seen++;
         chk("err_width", 32'(err_prev), 32'd0);
      end
      err_prev = frame_err;
   endtask

   task automatic tick(input logic v, input logic h, input logic [7:0] d);
      @(negedge clk);
      sample();
      cmos_vsync = v;
      cmos_href  = h;
      cmos_din   = d;
   endtask

   task automatic do_vsync();
      if (cur_cap && cur_sop && !cur_eop) exp_err++;
      vs_count++;
      cur_cap  = (vs_count > SKIP);
      cur_sop  = 1'b0;
      cur_eop  = 1'b0;
      cur_line = 0;
      mdl_pix  = 0;
      byte_ctr = 0;
      pix_seen = 0;
      sop_seen = 0;
      eop_seen = 0;
      tick(1'b1, 1'b0, 8'd0);
      tick(1'b1, 1'b0, 8'd0);
      repeat (3) tick(1'b0, 1'b0, 8'd0);
   endtask

   task automatic model_line();
      int np;
      np = (ln / 2 < H) ? ln / 2 : H;
      if (cur_cap && cur_line < V) begin
         for (int i = 0; i < np; i++) begin
            px_t p;
            p.d = {lb[2*i], lb[2*i+1]};
            p.s = (cur_line == 0) && (i == 0);
            p.e = (cur_line == V - 1) && (i == H - 1);
            if (p.s) cur_sop = 1'b1;
            if (p.e) cur_eop = 1'b1;
            expq.push_back(p);
            mdl_pix++;
         end
      end
      cur_line++;
   endtask

   task automatic fill_line(input int n, input bit rnd);
      ln = n;
      for (int i = 0; i < n; i++) begin
         lb[i] = rnd ? 8'($urandom) : 8'(byte_ctr);
         byte_ctr++;
      end
   endtask

   task automatic send_line();
      model_line();
      for (int i = 0; i < ln; i++) tick(1'b0, 1'b1, lb[i]);
      repeat (3) tick(1'b0, 1'b0, 8'd0);
   endtask

   task automatic run_row(input int idx);
      row_t r;
      r = tbl[idx];
      do_vsync();
      for (int l = 0; l < int'(r.nlines); l++) begin
         fill_line(int'(r.len[l]), 1'b0);
         send_line();
      end
      chk($sformatf("row%0d_pix", idx), 32'(pix_seen), 32'(r.exp_pix));
      chk($sformatf("row%0d_sop", idx), 32'(sop_seen), 32'(r.exp_sop));
      chk($sformatf("row%0d_eop", idx), 32'(eop_seen), 32'(r.exp_eop));
      chk($sformatf("row%0d_model_pix", idx), 32'(pix_seen), 32'(mdl_pix));
      chk($sformatf("row%0d_queue_empty", idx), 32'(expq.size()), 32'd0);
      chk($sformatf("row%0d_err", idx), 32'(err_seen), 32'(exp_err));
   endtask

   function automatic row_t mk(input int nl, input int l0, input int l1, input int l2,
                               input int l3, input int l4, input int l5,
                               input int pix, input bit s, input bit e);
      row_t r;
      r.nlines = 8'(nl);
      r.len[0] = 8'(l0); r.len[1] = 8'(l1); r.len[2] = 8'(l2);
      r.len[3] = 8'(l3); r.len[4] = 8'(l4); r.len[5] = 8'(l5);
      r.exp_pix = 8'(pix);
      r.exp_sop = s;
      r.exp_eop = e;
      return r;
   endfunction

   initial begin
      tbl[0]  = mk(4, 16, 16, 16, 16, 0, 0, 0, 0, 0);
      tbl[1]  = mk(4, 16, 16, 16, 16, 0, 0, 0, 0, 0);
      tbl[2]  = mk(4, 16, 16, 16, 16, 0, 0, 32, 1, 1);
      tbl[3]  = mk(4, 16, 16, 16, 16, 0, 0, 32, 1, 1);
      tbl[4]  = mk(4, 20, 9, 16, 16, 0, 0, 28, 1, 1);
      tbl[5]  = mk(6, 16, 16, 16, 16, 16, 16, 32, 1, 1);
      tbl[6]  = mk(2, 16, 16, 0, 0, 0, 0, 16, 1, 0);
      tbl[7]  = mk(4, 16, 16, 16, 16, 0, 0, 32, 1, 1);
      tbl[8]  = mk(4, 16, 16, 16, 16, 0, 0, 0, 0, 0);
      tbl[9]  = mk(4, 16, 16, 16, 16, 0, 0, 0, 0, 0);
      tbl[10] = mk(4, 16, 16, 16, 16, 0, 0, 32, 1, 1);

      vs_count = 0; cur_line = 0; exp_err = 0; mdl_pix = 0; byte_ctr = 0;
      cur_cap = 0; cur_sop = 0; cur_eop = 0; ln = 0;
      pix_seen = 0; sop_seen = 0; eop_seen = 0; err_seen = 0; err_prev = 0;

      repeat (3) tick(1'b0, 1'b0, 8'd0);
      chk("reset_outputs", 32'({dout_vld, dout_sop, dout_eop, dout, frame_err}), 32'd0);
      rst_n = 1'b1;
      repeat (3) tick(1'b0, 1'b0, 8'd0);

      for (int i = 0; i < 8; i++) begin
         run_row(i);
         if (i == 2) begin
            chk("frame3_first", 32'({first_sop, first_dout}), 32'({1'b1, 16'h0001}));
            chk("frame3_last", 32'({last_eop, last_dout}), 32'({1'b1, 16'h3E3F}));
         end
         if (i == 7) begin
            chk("err_after_short_frame", 32'(err_seen), 32'd1);
            chk("sop_after_err", 32'({first_sop, first_dout}), 32'({1'b1, 16'h0001}));
         end
      end

      // low byte captured at edge t: visible only in the cycle after edge t+1
      do_vsync();
      ln = 2; lb[0] = 8'hA5; lb[1] = 8'h3C;
      model_line();
      tick(1'b0, 1'b1, 8'hA5);
      tick(1'b0, 1'b1, 8'h3C);
      tick(1'b0, 1'b0, 8'd0);
      chk("lat_after_t", 32'(s_vld), 32'd0);
      tick(1'b0, 1'b0, 8'd0);
      chk("lat_after_t1", 32'({s_vld, s_sop, s_eop, s_dout}), 32'({1'b1, 1'b1, 1'b0, 16'hA53C}));
      tick(1'b0, 1'b0, 8'd0);
      chk("lat_after_t2", 32'(s_vld), 32'd0);
      repeat (2) tick(1'b0, 1'b0, 8'd0);

      for (int f = 0; f < 4; f++) begin
         int nl;
         do_vsync();
         nl = $urandom_range(1, 6);
         for (int l = 0; l < nl; l++) begin
            fill_line($urandom_range(1, 22), 1'b1);
            send_line();
         end
         chk($sformatf("rand%0d_pix", f), 32'(pix_seen), 32'(mdl_pix));
         chk($sformatf("rand%0d_queue_empty", f), 32'(expq.size()), 32'd0);
         chk($sformatf("rand%0d_err", f), 32'(err_seen), 32'(exp_err));
      end

      // reset pulled mid-line right after a pixel is presented
      do_vsync();
      tick(1'b0, 1'b1, 8'h11);
      tick(1'b0, 1'b1, 8'h22);
      tick(1'b0, 1'b1, 8'h33);
      @(posedge clk);
      #1;
      chk("pre_reset_pixel", 32'({dout_vld, dout}), 32'({1'b1, 16'h1122}));
      rst_n = 1'b0;
      cmos_href = 1'b0;
      #1;
      chk("reset_midline", 32'({dout_vld, dout_sop, dout_eop, dout, frame_err}), 32'd0);
      expq.delete();
      vs_count = 0; cur_cap = 0; cur_sop = 0; cur_eop = 0;
      repeat (3) tick(1'b0, 1'b0, 8'd0);
      rst_n = 1'b1;
      repeat (3) tick(1'b0, 1'b0, 8'd0);

      for (int i = 8; i < 11; i++) run_row(i);

      chk("final_err_count", 32'(err_seen), 32'(exp_err));
      chk("final_queue_empty", 32'(expq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
